// File: rtl/alu_unit_pkg.sv
// Shared definitions for the ALU execution unit: RoB tag width and op-code encodings.
package alu_unit_pkg;

  localparam int unsigned RobAddr = 4;
  localparam int unsigned OpW     = 6;
  localparam int unsigned XLen    = 32;

  typedef enum logic [OpW-1:0] {
    OpNop  = 6'd0,
    OpAdd  = 6'd1,
    OpSub  = 6'd2,
    OpAnd  = 6'd3,
    OpOr   = 6'd4,
    OpXor  = 6'd5,
    OpSll  = 6'd6,
    OpSrl  = 6'd7,
    OpSra  = 6'd8,
    OpSlt  = 6'd9,
    OpSltu = 6'd10,
    OpBeq  = 6'd11,
    OpBne  = 6'd12,
    OpBlt  = 6'd13,
    OpBge  = 6'd14,
    OpBltu = 6'd15,
    OpBgeu = 6'd16
  } alu_op_e;

endpackage

// File: rtl/alu_unit_cmp.sv
// Combinational 32-bit comparator shared by set-less-than and branch ops.
module alu_cmp
  import alu_unit_pkg::*;
(
  input  logic [XLen-1:0] a_i,
  input  logic [XLen-1:0] b_i,
  output logic            eq_o,
  output logic            lt_o,
  output logic            ltu_o
);

  assign eq_o  = (a_i == b_i);
  assign lt_o  = ($signed(a_i) < $signed(b_i));
  assign ltu_o = (a_i < b_i);

endmodule

// File: rtl/alu_unit.sv
// Two-stage pipelined integer ALU: E1 registers operands and precomputed arithmetic,
// E2 selects the result and drives the broadcast bus.
module alu_unit
  import alu_unit_pkg::*;
(
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               ALU_clear,
  input  logic [XLen-1:0]    alu_rs1,
  input  logic [XLen-1:0]    alu_rs2,
  input  logic [OpW-1:0]     alu_op,
  input  logic [RobAddr-1:0] alu_id,
  output logic               alu_valid,
  output logic [RobAddr-1:0] alu_robid,
  output logic [XLen-1:0]    alu_val
);

  logic               flush;
  logic               cmp_eq, cmp_lt, cmp_ltu;

  logic               e1_valid_q;
  logic [OpW-1:0]     e1_op_q;
  logic [RobAddr-1:0] e1_id_q;
  logic [XLen-1:0]    e1_rs1_q, e1_rs2_q;
  logic [XLen-1:0]    e1_sum_q, e1_diff_q;
  logic               e1_eq_q, e1_lt_q, e1_ltu_q;

  logic [XLen-1:0]    result_d;
  logic               alu_valid_q;
  logic [RobAddr-1:0] alu_robid_q;
  logic [XLen-1:0]    alu_val_q;

  assign flush = rst_in | ALU_clear;

  alu_cmp u_cmp (
    .a_i   (alu_rs1),
    .b_i   (alu_rs2),
    .eq_o  (cmp_eq),
    .lt_o  (cmp_lt),
    .ltu_o (cmp_ltu)
  );

  // Flush wins over the stall so a misprediction is never held off by rdy_in.
  always_ff @(posedge clk_in) begin
    if (flush) begin
      e1_valid_q <= 1'b0;
      e1_op_q    <= '0;
      e1_id_q    <= '0;
      e1_rs1_q   <= '0;
      e1_rs2_q   <= '0;
      e1_sum_q   <= '0;
      e1_diff_q  <= '0;
      e1_eq_q    <= 1'b0;
      e1_lt_q    <= 1'b0;
      e1_ltu_q   <= 1'b0;
    end else if (rdy_in) begin
      e1_valid_q <= (alu_op != OpNop);
      e1_op_q    <= alu_op;
      e1_id_q    <= alu_id;
      e1_rs1_q   <= alu_rs1;
      e1_rs2_q   <= alu_rs2;
      e1_sum_q   <= alu_rs1 + alu_rs2;
      e1_diff_q  <= alu_rs1 - alu_rs2;
      e1_eq_q    <= cmp_eq;
      e1_lt_q    <= cmp_lt;
      e1_ltu_q   <= cmp_ltu;
    end
  end

  always_comb begin
    result_d = '0;
    case (e1_op_q)
      OpAdd:  result_d = e1_sum_q;
      OpSub:  result_d = e1_diff_q;
      OpAnd:  result_d = e1_rs1_q & e1_rs2_q;
      OpOr:   result_d = e1_rs1_q | e1_rs2_q;
      OpXor:  result_d = e1_rs1_q ^ e1_rs2_q;
      OpSll:  result_d = e1_rs1_q << e1_rs2_q[4:0];
      OpSrl:  result_d = e1_rs1_q >> e1_rs2_q[4:0];
      OpSra:  result_d = $unsigned($signed(e1_rs1_q) >>> e1_rs2_q[4:0]);
      OpSlt:  result_d = {{(XLen-1){1'b0}}, e1_lt_q};
      OpSltu: result_d = {{(XLen-1){1'b0}}, e1_ltu_q};
      OpBeq:  result_d = {{(XLen-1){1'b0}}, e1_eq_q};
      OpBne:  result_d = {{(XLen-1){1'b0}}, ~e1_eq_q};
      OpBlt:  result_d = {{(XLen-1){1'b0}}, e1_lt_q};
      OpBge:  result_d = {{(XLen-1){1'b0}}, ~e1_lt_q};
      OpBltu: result_d = {{(XLen-1){1'b0}}, e1_ltu_q};
      OpBgeu: result_d = {{(XLen-1){1'b0}}, ~e1_ltu_q};
      default: result_d = '0;
    endcase
  end

  // Tag and value are forced to zero on idle cycles rather than holding stale data.
  always_ff @(posedge clk_in) begin
    if (flush) begin
      alu_valid_q <= 1'b0;
      alu_robid_q <= '0;
      alu_val_q   <= '0;
    end else if (rdy_in) begin
      alu_valid_q <= e1_valid_q;
      alu_robid_q <= e1_valid_q ? e1_id_q : '0;
      alu_val_q   <= e1_valid_q ? result_d : '0;
    end
  end

  assign alu_valid = alu_valid_q;
  assign alu_robid = alu_robid_q;
  assign alu_val   = alu_val_q;

endmodule

// File: tb/tb_alu_unit.sv
// Scoreboard bench for alu_unit: the driver queues expected bus contents per pipeline
// advance; a negedge monitor pops and compares every cycle.
module tb_alu_unit;
  import alu_unit_pkg::*;

  typedef struct packed {
    logic               v;
    logic [RobAddr-1:0] tag;
    logic [XLen-1:0]    val;
  } exp_t;

  localparam int KNone  = 0;
  localparam int KFlush = 1;
  localparam int KAdv   = 2;
  localparam int KHold  = 3;

  logic               clk_in = 1'b0;
  logic               rst_in, rdy_in, ALU_clear;
  logic [XLen-1:0]    alu_rs1, alu_rs2;
  logic [OpW-1:0]     alu_op;
  logic [RobAddr-1:0] alu_id;
  logic               alu_valid;
  logic [RobAddr-1:0] alu_robid;
  logic [XLen-1:0]    alu_val;

  exp_t  sb_q[$];
  exp_t  last_exp = '0;
  int    edge_kind = KNone;
  int    n_vec = 0;
  int    n_err = 0;
  string cur_name = "init";

  alu_unit dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .ALU_clear (ALU_clear),
    .alu_rs1   (alu_rs1),
    .alu_rs2   (alu_rs2),
    .alu_op    (alu_op),
    .alu_id    (alu_id),
    .alu_valid (alu_valid),
    .alu_robid (alu_robid),
    .alu_val   (alu_val)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input exp_t e);
    n_vec++;
    if (alu_valid !== e.v || alu_robid !== e.tag || alu_val !== e.val) begin
      n_err++;
      $display("FAIL %s @%0t: got valid=%0b tag=%0d val=%h, want valid=%0b tag=%0d val=%h",
               cur_name, $time, alu_valid, alu_robid, alu_val, e.v, e.tag, e.val);
    end
  endtask

  // Monitor: one comparison per clock, keyed on what the previous edge did.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_in);
      if (edge_kind == KFlush) begin
        e = '0;
        check(e);
        last_exp = e;
      end else if (edge_kind == KAdv) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL %s @%0t: scoreboard underflow, got valid=%0b tag=%0d val=%h",
                   cur_name, $time, alu_valid, alu_robid, alu_val);
        end else begin
          e = sb_q.pop_front();
          check(e);
          last_exp = e;
        end
      end else if (edge_kind == KHold) begin
        check(last_exp);
      end
    end
  end

  // Drive one cycle, then update the expected-pipeline model at the capturing edge.
  task automatic step(input logic rst, input logic clr, input logic rdy, input logic [OpW-1:0] op,
                      input logic [XLen-1:0] a, input logic [XLen-1:0] b,
                      input logic [RobAddr-1:0] tag, input logic [XLen-1:0] res);
    exp_t e;
    rst_in    = rst;
    ALU_clear = clr;
    rdy_in    = rdy;
    alu_op    = op;
    alu_rs1   = a;
    alu_rs2   = b;
    alu_id    = tag;
    @(posedge clk_in);
    if (rst || clr) begin
      sb_q.delete();
      sb_q.push_back('0);
      edge_kind = KFlush;
    end else if (rdy) begin
      e = (op == OpNop) ? '0 : '{v: 1'b1, tag: tag, val: res};
      sb_q.push_back(e);
      edge_kind = KAdv;
    end else begin
      edge_kind = KHold;
    end
    #1;
  endtask

  task automatic do_op(input logic [OpW-1:0] op, input logic [XLen-1:0] a,
                       input logic [XLen-1:0] b, input logic [RobAddr-1:0] tag,
                       input logic [XLen-1:0] res);
    step(1'b0, 1'b0, 1'b1, op, a, b, tag, res);
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, OpNop, '0, '0, '0, '0);
  endtask

  initial begin
    cur_name = "reset";
    step(1'b1, 1'b0, 1'b0, OpAdd, 32'd9, 32'd9, 4'd9, 32'd0);
    step(1'b1, 1'b0, 1'b1, OpAdd, 32'd9, 32'd9, 4'd9, 32'd0);
    nop(2);

    cur_name = "single_add";
    do_op(OpAdd, 32'd5, 32'd7, 4'd3, 32'd12);
    nop(3);

    cur_name = "back_to_back";
    do_op(OpSub,  32'd0,          32'd1,          4'd1, 32'hFFFF_FFFF);
    do_op(OpSra,  32'h8000_0000,  32'd4,          4'd2, 32'hF800_0000);
    do_op(OpSltu, 32'd1,          32'hFFFF_FFFF,  4'd3, 32'd1);
    do_op(OpBge,  32'hFFFF_FFFF,  32'd0,          4'd4, 32'd0);
    nop(2);

    cur_name = "ops_mix";
    do_op(OpSll,  32'd1,          32'd33,         4'd5,  32'd2);
    do_op(OpSrl,  32'h8000_0000,  32'd31,         4'd6,  32'd1);
    do_op(OpAdd,  32'hFFFF_FFFF,  32'd1,          4'd7,  32'd0);
    do_op(OpAnd,  32'h0000_F0F0,  32'h0000_FF00,  4'd8,  32'h0000_F000);
    do_op(OpSlt,  32'hFFFF_FFFF,  32'd1,          4'd9,  32'd1);
    do_op(OpBeq,  32'd5,          32'd5,          4'd10, 32'd1);
    do_op(OpBne,  32'd5,          32'd5,          4'd11, 32'd0);
    do_op(OpBlt,  32'd1,          32'hFFFF_FFFF,  4'd12, 32'd0);
    do_op(OpBltu, 32'd1,          32'hFFFF_FFFF,  4'd13, 32'd1);
    do_op(OpBgeu, 32'd0,          32'd0,          4'd14, 32'd1);
    do_op(6'd63,  32'd7,          32'd7,          4'd15, 32'd0);
    nop(2);

    cur_name = "flush";
    do_op(OpAdd, 32'd1, 32'd2, 4'd8, 32'd3);
    step(1'b0, 1'b1, 1'b1, OpSub, 32'd5, 32'd3, 4'd9, 32'd2);
    do_op(OpOr, 32'h0000_00F0, 32'h0000_000F, 4'd7, 32'h0000_00FF);
    nop(2);

    cur_name = "flush_during_stall";
    do_op(OpAdd, 32'd1, 32'd1, 4'd1, 32'd2);
    step(1'b0, 1'b1, 1'b0, OpAdd, 32'd3, 32'd3, 4'd2, 32'd6);
    nop(2);

    cur_name = "stall";
    do_op(OpXor, 32'h0000_00FF, 32'h0000_000F, 4'd2, 32'h0000_00F0);
    do_op(OpAdd, 32'd2, 32'd3, 4'd6, 32'd5);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, OpSub, 32'd9, 32'd9, 4'd15, 32'd0);
    nop(3);

    cur_name = "bubbles";
    for (int i = 1; i <= 3; i++) begin
      nop(1);
      do_op(OpAdd, 32'd1, 32'd1, 4'(i), 32'd2);
    end
    nop(3);

    @(posedge clk_in);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
